ace_snoop_responder: RTL and testbench

ACE_SNOOP_RESPONDER -- requirements
Module: ace_snoop_responder

---
 rtl/ace_snoop_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_ace_snoop_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop at a time, looks up the line tag,
// answers on CR, streams the line on CD when data is transferred, then updates line state.
module ace_snoop_responder #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineWidth = 512,
  localparam int Beats = LineWidth / DataWidth,
  localparam int BeatWidth = (Beats > 1) ? $clog2(Beats) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic [AddrWidth-1:0] line_addr_o,
  output logic                 tag_req_o,
  input  logic                 tag_gnt_i,
  input  logic                 tag_rvalid_i,
  input  logic [2:0]           tag_state_i,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic [BeatWidth-1:0] data_beat_o,
  input  logic                 data_rvalid_i,
  input  logic [DataWidth-1:0] data_rdata_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic [1:0]           upd_op_o
);

  localparam int OffsetBits = $clog2(LineWidth / 8);
  localparam logic [AddrWidth-1:0] LineMask =
    ~((AddrWidth'(1) << OffsetBits) - AddrWidth'(1));
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(Beats - 1);
  localparam logic [4:0] RespError = 5'b00010;

  localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
  localparam logic [3:0] SNP_READ_NSD      = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

  localparam logic [1:0] OP_KEEP       = 2'd0;
  localparam logic [1:0] OP_INVALIDATE = 2'd1;
  localparam logic [1:0] OP_CLEAN      = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    TAG_REQ,
    TAG_WAIT,
    CR,
    CD_REQ,
    CD_WAIT,
    CD_SEND,
    UPD
  } state_e;

  state_e               state_reg, state_next;
  logic [AddrWidth-1:0] line_addr_reg, line_addr_next;
  logic [3:0]           snoop_reg, snoop_next;
  logic [4:0]           cr_resp_reg, cr_resp_next;
  logic [1:0]           upd_op_reg, upd_op_next;
  logic [BeatWidth-1:0] beat_reg, beat_next;
  logic [DataWidth-1:0] cd_data_reg, cd_data_next;

  logic                 tag_hit, tag_dirty, tag_shared;
  logic [4:0]           lookup_resp;
  logic [1:0]           lookup_op;

  function automatic logic is_supported(input logic [3:0] code);
    case (code)
      SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD,
      SNP_READ_UNIQUE, SNP_CLEAN_SHARED, SNP_CLEAN_INVALID,
      SNP_MAKE_INVALID: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  assign tag_hit    = tag_state_i[0];
  assign tag_dirty  = tag_state_i[1];
  assign tag_shared = tag_state_i[2];

  // Response bits are {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  always_comb begin
    lookup_resp = 5'b00000;
    lookup_op   = OP_KEEP;
    if (tag_hit) begin
      lookup_resp[4] = ~tag_shared;
      case (snoop_reg)
        SNP_READ_ONCE: begin
          lookup_resp[3] = 1'b1;
          lookup_resp[0] = 1'b1;
        end
        SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
          lookup_resp[3] = 1'b1;
          lookup_resp[2] = tag_dirty;
          lookup_resp[0] = 1'b1;
          lookup_op      = OP_CLEAN;
        end
        SNP_READ_UNIQUE: begin
          lookup_resp[2] = tag_dirty;
          lookup_resp[0] = 1'b1;
          lookup_op      = OP_INVALIDATE;
        end
        SNP_CLEAN_INVALID: begin
          lookup_resp[2] = tag_dirty;
          lookup_resp[0] = tag_dirty;
          lookup_op      = OP_INVALIDATE;
        end
        SNP_CLEAN_SHARED: begin
          lookup_resp[3] = 1'b1;
          lookup_resp[2] = tag_dirty;
          lookup_resp[0] = tag_dirty;
          lookup_op      = OP_CLEAN;
        end
        SNP_MAKE_INVALID: begin
          lookup_op      = OP_INVALIDATE;
        end
        default: begin
          lookup_resp = 5'b00000;
          lookup_op   = OP_KEEP;
        end
      endcase
    end
  end

  always_comb begin
    state_next     = state_reg;
    line_addr_next = line_addr_reg;
    snoop_next     = snoop_reg;
    cr_resp_next   = cr_resp_reg;
    upd_op_next    = upd_op_reg;
    beat_next      = beat_reg;
    cd_data_next   = cd_data_reg;
    case (state_reg)
      IDLE: begin
        if (ac_valid_i) begin
          line_addr_next = ac_addr_i & LineMask;
          snoop_next     = ac_snoop_i;
          if (is_supported(ac_snoop_i)) begin
            state_next = TAG_REQ;
          end else begin
            cr_resp_next = RespError;
            upd_op_next  = OP_KEEP;
            state_next   = CR;
          end
        end
      end
      TAG_REQ: begin
        if (tag_gnt_i) state_next = TAG_WAIT;
      end
      TAG_WAIT: begin
        if (tag_rvalid_i) begin
          cr_resp_next = lookup_resp;
          upd_op_next  = lookup_op;
          state_next   = CR;
        end
      end
      CR: begin
        if (cr_ready_i) begin
          if (cr_resp_reg[0])            state_next = CD_REQ;
          else if (upd_op_reg != OP_KEEP) state_next = UPD;
          else                            state_next = IDLE;
        end
      end
      CD_REQ: begin
        if (data_gnt_i) state_next = CD_WAIT;
      end
      CD_WAIT: begin
        if (data_rvalid_i) begin
          cd_data_next = data_rdata_i;
          state_next   = CD_SEND;
        end
      end
      CD_SEND: begin
        if (cd_ready_i) begin
          if (beat_reg == LastBeat) begin
            beat_next  = '0;
            state_next = (upd_op_reg != OP_KEEP) ? UPD : IDLE;
          end else begin
            beat_next  = beat_reg + BeatWidth'(1);
            state_next = CD_REQ;
          end
        end
      end
      UPD: begin
        if (upd_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      line_addr_reg <= '0;
      snoop_reg     <= '0;
      cr_resp_reg   <= '0;
      upd_op_reg    <= OP_KEEP;
      beat_reg      <= '0;
      cd_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      line_addr_reg <= line_addr_next;
      snoop_reg     <= snoop_next;
      cr_resp_reg   <= cr_resp_next;
      upd_op_reg    <= upd_op_next;
      beat_reg      <= beat_next;
      cd_data_reg   <= cd_data_next;
    end
  end

  // Handshake outputs decode the state register only, so no ready/gnt input reaches them.
  assign ac_ready_o  = (state_reg == IDLE);
  assign tag_req_o   = (state_reg == TAG_REQ);
  assign data_req_o  = (state_reg == CD_REQ);
  assign cr_valid_o  = (state_reg == CR);
  assign cd_valid_o  = (state_reg == CD_SEND);
  assign upd_valid_o = (state_reg == UPD);
  assign cd_last_o   = (state_reg == CD_SEND) && (beat_reg == LastBeat);
  assign cr_resp_o   = cr_resp_reg;
  assign cd_data_o   = cd_data_reg;
  assign line_addr_o = line_addr_reg;
  assign data_beat_o = beat_reg;
  assign upd_op_o    = upd_op_reg;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Bench for ace_snoop_responder: table of directed snoops, stall/reset corner sequences,
// and random snoops checked against a rule-level model of the snoop response table.
module tb_ace_snoop_responder;
  localparam int BEATS = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ac_valid_i, ac_ready_o;
  logic [63:0] ac_addr_i;
  logic [3:0]  ac_snoop_i;
  logic        cr_valid_o, cr_ready_i;
  logic [4:0]  cr_resp_o;
  logic        cd_valid_o, cd_ready_i, cd_last_o;
  logic [63:0] cd_data_o, line_addr_o;
  logic        tag_req_o, tag_gnt_i, tag_rvalid_i;
  logic [2:0]  tag_state_i;
  logic        data_req_o, data_gnt_i, data_rvalid_i;
  logic [2:0]  data_beat_o;
  logic [63:0] data_rdata_i;
  logic        upd_valid_o, upd_ready_i;
  logic [1:0]  upd_op_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ace_snoop_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .line_addr_o(line_addr_o),
    .tag_req_o(tag_req_o), .tag_gnt_i(tag_gnt_i), .tag_rvalid_i(tag_rvalid_i), .tag_state_i(tag_state_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_beat_o(data_beat_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_op_o(upd_op_o)
  );

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  code;
    logic [2:0]  ts;
    logic [4:0]  resp;
    logic [1:0]  op;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string tx, input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s %s: got 0x%0h required 0x%0h", tx, name, got, exp);
    end
  endtask

  // Contents the data array returns for a given line and beat.
  function automatic logic [63:0] line_data(input logic [63:0] line, input int beat);
    return {line[31:0] ^ 32'hA5A5_5A5A, 29'd0, 3'(beat)};
  endfunction

  // Snoop response rules expressed per transaction family.
  function automatic void ref_model(input logic [3:0] code, input logic [2:0] ts,
                                    output logic [4:0] resp, output logic [1:0] op);
    bit hit, dirty, shared, is_read, keeps_copy, dt, pd;
    hit = ts[0]; dirty = ts[1]; shared = ts[2];
    resp = 5'b00000;
    op   = 2'd0;
    if (!(code inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1101})) begin
      resp = 5'b00010;
      return;
    end
    if (!hit) return;
    is_read    = code inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111};
    keeps_copy = code inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000};
    dt = is_read ? 1'b1 : ((code == 4'b1101) ? 1'b0 : dirty);
    pd = (code == 4'b0000 || code == 4'b1101) ? 1'b0 : dirty;
    op = (code == 4'b0000) ? 2'd0 : (keeps_copy ? 2'd2 : 2'd1);
    resp = {!shared, keeps_copy, pd, 1'b0, dt};
  endfunction

  task automatic check_reset_outputs(input string tx);
    check(tx, "rst_flags", {57'd0, ac_ready_o, cr_valid_o, cd_valid_o, cd_last_o, tag_req_o, data_req_o, upd_valid_o},
          64'b1000000);
    check(tx, "rst_cr_resp", {59'd0, cr_resp_o}, 64'd0);
    check(tx, "rst_cd_data", cd_data_o, 64'd0);
    check(tx, "rst_line_addr", line_addr_o, 64'd0);
    check(tx, "rst_data_beat", {61'd0, data_beat_o}, 64'd0);
    check(tx, "rst_upd_op", {62'd0, upd_op_o}, 64'd0);
  endtask

  task automatic idle_inputs();
    ac_valid_i = 0; ac_addr_i = '0; ac_snoop_i = '0;
    cr_ready_i = 0; cd_ready_i = 0; upd_ready_i = 0;
    tag_gnt_i = 0; tag_rvalid_i = 0; tag_state_i = '0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;
  endtask

  task automatic do_snoop(input string tx, input logic [63:0] addr, input logic [3:0] code, input logic [2:0] ts,
                          input logic [4:0] exp_resp, input logic [1:0] exp_op, input bit hold,
                          input int cr_stall, input int cd_stall_beat, input int cd_stall_len,
                          input bit rnd, input int abort_beat);
    logic [63:0] exp_line;
    int exp_beats, exp_upd, exp_tag;
    bit accepted, done, aborted;
    int tag_pend, data_pend, data_beat_lat;
    int tag_hs, cr_hs, cd_hs, upd_hs, cr_cnt, cd_cnt, upd_cnt, cd_stall, upd_stall, cr_stall_now;
    int line_bad, resp_bad, cd_bad, upd_bad, order_bad;
    exp_line  = addr & ~64'h3F;
    exp_beats = exp_resp[0] ? BEATS : 0;
    exp_upd   = (exp_op != 2'd0) ? 1 : 0;
    exp_tag   = exp_resp[1] ? 0 : 1;
    accepted = 0; done = 0; aborted = 0;
    tag_pend = 0; data_pend = 0; data_beat_lat = 0;
    tag_hs = 0; cr_hs = 0; cd_hs = 0; upd_hs = 0; cr_cnt = 0; cd_cnt = 0; upd_cnt = 0; cd_stall = 0;
    line_bad = 0; resp_bad = 0; cd_bad = 0; upd_bad = 0; order_bad = 0;
    cr_stall_now = rnd ? $urandom_range(0, 3) : cr_stall;
    upd_stall    = rnd ? $urandom_range(0, 3) : 0;
    for (int cyc = 0; cyc < 600 && !done && !aborted; cyc++) begin
      @(negedge clk);
      tag_gnt_i = 0; tag_rvalid_i = 0; tag_state_i = ~ts;
      data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = {$urandom, $urandom};
      cr_ready_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      cd_ready_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      upd_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (tag_pend > 0) begin
        tag_pend--;
        if (tag_pend == 0) begin tag_rvalid_i = 1; tag_state_i = ts; end
      end
      if (data_pend > 0) begin
        data_pend--;
        if (data_pend == 0) begin data_rvalid_i = 1; data_rdata_i = line_data(line_addr_o, data_beat_lat); end
      end
      if (!accepted) begin
        if (ac_ready_o) begin
          accepted = 1; ac_valid_i = 1; ac_addr_i = addr; ac_snoop_i = code;
        end
      end else if (ac_ready_o) begin
        done = 1;
        idle_inputs();
      end else begin
        if (!hold) begin
          ac_valid_i = 0; ac_addr_i = {$urandom, $urandom}; ac_snoop_i = 4'($urandom);
        end
        if (line_addr_o !== exp_line) line_bad++;
        if (tag_req_o && tag_pend == 0 && $urandom_range(0, 2) != 0) begin
          tag_gnt_i = 1; tag_hs++; tag_pend = $urandom_range(1, 3);
        end
        if (data_req_o) begin
          if (int'(data_beat_o) != cd_hs) cd_bad++;
          if (data_pend == 0 && $urandom_range(0, 2) != 0) begin
            data_gnt_i = 1; data_pend = $urandom_range(1, 3); data_beat_lat = int'(data_beat_o);
          end
        end
        if (cr_valid_o) begin
          if (cr_resp_o !== exp_resp) resp_bad++;
          cr_cnt++;
          cr_ready_i = (cr_cnt > cr_stall_now);
          if (cr_ready_i) cr_hs++;
        end
        if (cd_valid_o) begin
          if (cr_hs == 0) order_bad++;
          if (cd_data_o !== line_data(exp_line, cd_hs) || cd_last_o !== (cd_hs == BEATS - 1)) cd_bad++;
          if (cd_hs == abort_beat) begin
            rst_i = 1;
            #1;
            check_reset_outputs(tx);
            check(tx, "rst_beats_before_abort", 64'(cd_hs), 64'(abort_beat));
            idle_inputs();
            aborted = 1;
            @(negedge clk);
            rst_i = 0;
          end else begin
            cd_cnt++;
            if (cd_cnt == 1) cd_stall = (cd_hs == cd_stall_beat) ? cd_stall_len : (rnd ? $urandom_range(0, 2) : 0);
            cd_ready_i = (cd_cnt > cd_stall);
            if (cd_ready_i) begin cd_hs++; cd_cnt = 0; end
          end
        end
        if (upd_valid_o) begin
          if (upd_op_o !== exp_op) upd_bad++;
          if (cd_hs != exp_beats || cr_hs == 0) order_bad++;
          upd_cnt++;
          upd_ready_i = (upd_cnt > upd_stall);
          if (upd_ready_i) upd_hs++;
        end
      end
    end
    if (aborted) begin
      $display("snoop %s code=%b addr=0x%h reset after %0d beats", tx, code, addr, cd_hs);
      return;
    end
    check(tx, "completed", 64'(done), 64'd1);
    check(tx, "line_addr_errors", 64'(line_bad), 64'd0);
    check(tx, "cr_handshakes", 64'(cr_hs), 64'd1);
    check(tx, "cr_resp_errors", 64'(resp_bad), 64'd0);
    check(tx, "tag_lookups", 64'(tag_hs), 64'(exp_tag));
    check(tx, "cd_beats", 64'(cd_hs), 64'(exp_beats));
    check(tx, "cd_payload_errors", 64'(cd_bad), 64'd0);
    check(tx, "upd_handshakes", 64'(upd_hs), 64'(exp_upd));
    check(tx, "upd_op_errors", 64'(upd_bad), 64'd0);
    check(tx, "ordering_errors", 64'(order_bad), 64'd0);
    $display("snoop %s code=%b addr=0x%h resp=%b beats=%0d upd=%0d", tx, code, addr, exp_resp, cd_hs, upd_hs);
  endtask

  initial begin
    logic [3:0] sup_codes [8];
    logic [3:0] code;
    logic [2:0] ts;
    logic [4:0] resp;
    logic [1:0] op;

    vecs[0]  = '{64'h0000_0000_1000_0048, 4'b0001, 3'b011, 5'b11101, 2'd2};
    vecs[1]  = '{64'h0000_0000_2000_1234, 4'b1001, 3'b101, 5'b00000, 2'd1};
    vecs[2]  = '{64'h0000_0000_3000_0040, 4'b0111, 3'b000, 5'b00000, 2'd0};
    vecs[3]  = '{64'h0000_0000_4000_0008, 4'b0100, 3'b011, 5'b00010, 2'd0};
    vecs[4]  = '{64'h1234_5678_9ABC_DEF0, 4'b0000, 3'b111, 5'b01001, 2'd0};
    vecs[5]  = '{64'h0000_0000_5000_007F, 4'b0111, 3'b011, 5'b10101, 2'd1};
    vecs[6]  = '{64'h0000_0000_6000_0080, 4'b1000, 3'b011, 5'b11101, 2'd2};
    vecs[7]  = '{64'h0000_0000_7000_00C1, 4'b1101, 3'b011, 5'b10000, 2'd1};
    vecs[8]  = '{64'h0000_0000_8000_0100, 4'b0010, 3'b101, 5'b01001, 2'd2};
    vecs[9]  = '{64'h0000_0000_9000_013F, 4'b0011, 3'b001, 5'b11001, 2'd2};
    vecs[10] = '{64'h0000_0000_A000_0200, 4'b1001, 3'b011, 5'b10101, 2'd1};
    vecs[11] = '{64'h0000_0000_B000_0240, 4'b1000, 3'b110, 5'b00000, 2'd0};
    vecs[12] = '{64'h0000_0000_C000_0280, 4'b1111, 3'b111, 5'b00010, 2'd0};
    sup_codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1101};

    idle_inputs();
    rst_i = 1;
    repeat (3) @(negedge clk);
    check_reset_outputs("power_on");
    rst_i = 0;

    for (int i = 0; i < 13; i++)
      do_snoop($sformatf("vec%0d", i), vecs[i].addr, vecs[i].code, vecs[i].ts, vecs[i].resp, vecs[i].op,
               1'b0, 0, -1, 0, 1'b0, -1);

    do_snoop("stall_hold", 64'h0000_0000_2000_0F10, 4'b0001, 3'b011, 5'b11101, 2'd2, 1'b1, 4, 2, 3, 1'b0, -1);
    do_snoop("abort_beat5", 64'h0000_0000_3000_00C8, 4'b0001, 3'b011, 5'b11101, 2'd2, 1'b0, 0, -1, 0, 1'b0, 5);
    do_snoop("after_reset", 64'h0000_0000_3000_00C8, 4'b0000, 3'b111, 5'b01001, 2'd0, 1'b0, 0, -1, 0, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      code = ($urandom_range(0, 3) != 0) ? sup_codes[$urandom_range(0, 7)] : 4'($urandom);
      ts   = 3'($urandom);
      ref_model(code, ts, resp, op);
      do_snoop($sformatf("rand%0d", i), {$urandom, $urandom}, code, ts, resp, op,
               1'($urandom_range(0, 1)), 0, -1, 0, 1'b1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
